// File: rtl/soc.sv
// Three-stage MIPS32-subset SoC: a CPU core (IF, ID, EXE) with a word-addressed
// instruction memory and a data memory, all on one clock.

module soc_imem #(
    parameter int WORDS = 1024
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [29:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [29:0] raddr_i,
    output logic [31:0] rdata_o
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [29:0] DEPTH = 30'(WORDS);

    logic [31:0]   inst_array [0:WORDS-1];
    logic [AW-1:0] widx;
    logic [AW-1:0] ridx;

    assign widx    = AW'(waddr_i % DEPTH);
    assign ridx    = AW'(raddr_i % DEPTH);
    assign rdata_o = inst_array[ridx];

    // Load port is tied off at the top; contents are normally preloaded by the bench.
    always_ff @(posedge clk) begin
        if (we_i) inst_array[widx] <= wdata_i;
    end
endmodule

module soc_dmem #(
    parameter int WORDS = 1024
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [29:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [29:0] DEPTH = 30'(WORDS);

    logic [31:0]   data_array [0:WORDS-1];
    logic [AW-1:0] idx;

    assign idx     = AW'(addr_i % DEPTH);
    assign rdata_o = data_array[idx];

    always_ff @(posedge clk) begin
        if (we_i) data_array[idx] <= wdata_i;
    end
endmodule

module soc_gpr (
    input  logic        clk,
    input  logic        srst_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);
    logic [31:0] array_reg [0:31];

    assign rdata_a_o = array_reg[raddr_a_i];
    assign rdata_b_o = array_reg[raddr_b_i];

    always_ff @(posedge clk) begin
        if (srst_i) begin
            for (int i = 0; i < 32; i++) array_reg[i] <= '0;
        end else if (we_i && waddr_i != 5'd0) begin
            array_reg[waddr_i] <= wdata_i;
        end
    end
endmodule

module soc_id_exe_reg (
    input  logic        clk,
    input  logic        srst_i,
    input  logic        en_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] exe_instr_out,
    output logic [31:0] exe_pc_o,
    output logic [31:0] a_o,
    output logic [31:0] b_o
);
    logic [31:0] instr_q, pc_q, a_q, b_q;

    always_ff @(posedge clk) begin
        if (srst_i || (en_i && flush_i)) begin
            instr_q <= '0;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (en_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            a_q     <= a_i;
            b_q     <= b_i;
        end
    end

    assign exe_instr_out = instr_q;
    assign exe_pc_o      = pc_q;
    assign a_o           = a_q;
    assign b_o           = b_q;
endmodule

module soc_cpu (
    input  logic        clk,
    input  logic        srst_i,
    input  logic        en_i,
    output logic [29:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [29:0] dmem_addr_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i
);
    logic [31:0] pc_q, pc_d, if_pc_q, if_instr_q;
    logic [31:0] rf_a, rf_b, id_a, id_b;
    logic [31:0] exe_pc_out, exe_instr, exe_a, exe_b;
    logic [31:0] simm, zimm, sum_imm, pc4, target, wb_data;
    logic [4:0]  wb_addr;
    logic        wb_en, taken, st_en;

    assign imem_addr_o = pc_q[31:2];
    assign pc_d        = taken ? target : pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (srst_i) begin
            pc_q       <= '0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else if (en_i) begin
            pc_q       <= pc_d;
            if_pc_q    <= taken ? 32'd0 : pc_q;
            if_instr_q <= taken ? 32'd0 : imem_data_i;
        end
    end

    soc_gpr gpr_inst (
        .clk       (clk),
        .srst_i    (srst_i),
        .we_i      (wb_en && en_i),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (if_instr_q[25:21]),
        .raddr_b_i (if_instr_q[20:16]),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b)
    );

    // Bypass the value EXE writes this cycle so dependent instructions never stall.
    assign id_a = (wb_en && wb_addr != 5'd0 && wb_addr == if_instr_q[25:21]) ? wb_data : rf_a;
    assign id_b = (wb_en && wb_addr != 5'd0 && wb_addr == if_instr_q[20:16]) ? wb_data : rf_b;

    soc_id_exe_reg id_exe_reg_inst (
        .clk           (clk),
        .srst_i        (srst_i),
        .en_i          (en_i),
        .flush_i       (taken),
        .instr_i       (if_instr_q),
        .pc_i          (if_pc_q),
        .a_i           (id_a),
        .b_i           (id_b),
        .exe_instr_out (exe_instr),
        .exe_pc_o      (exe_pc_out),
        .a_o           (exe_a),
        .b_o           (exe_b)
    );

    assign simm    = {{16{exe_instr[15]}}, exe_instr[15:0]};
    assign zimm    = {16'h0000, exe_instr[15:0]};
    assign sum_imm = exe_a + simm;
    assign pc4     = exe_pc_out + 32'd4;

    always_comb begin
        wb_en   = 1'b0;
        wb_addr = exe_instr[20:16];
        wb_data = '0;
        taken   = 1'b0;
        target  = pc4;
        st_en   = 1'b0;
        case (exe_instr[31:26])
            6'h00: begin
                wb_addr = exe_instr[15:11];
                wb_en   = 1'b1;
                case (exe_instr[5:0])
                    6'h20, 6'h21: wb_data = exe_a + exe_b;
                    6'h22, 6'h23: wb_data = exe_a - exe_b;
                    6'h24:        wb_data = exe_a & exe_b;
                    6'h25:        wb_data = exe_a | exe_b;
                    6'h26:        wb_data = exe_a ^ exe_b;
                    6'h27:        wb_data = ~(exe_a | exe_b);
                    6'h2a:        wb_data = {31'b0, $signed(exe_a) < $signed(exe_b)};
                    6'h2b:        wb_data = {31'b0, exe_a < exe_b};
                    6'h00:        wb_data = exe_b << exe_instr[10:6];
                    6'h02:        wb_data = exe_b >> exe_instr[10:6];
                    6'h03:        wb_data = 32'($signed(exe_b) >>> exe_instr[10:6]);
                    6'h08: begin
                        wb_en  = 1'b0;
                        taken  = 1'b1;
                        target = exe_a;
                    end
                    default:      wb_en = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin wb_en = 1'b1; wb_data = sum_imm; end
            6'h0a: begin wb_en = 1'b1; wb_data = {31'b0, $signed(exe_a) < $signed(simm)}; end
            6'h0c: begin wb_en = 1'b1; wb_data = exe_a & zimm; end
            6'h0d: begin wb_en = 1'b1; wb_data = exe_a | zimm; end
            6'h0e: begin wb_en = 1'b1; wb_data = exe_a ^ zimm; end
            6'h0f: begin wb_en = 1'b1; wb_data = {exe_instr[15:0], 16'h0000}; end
            6'h23: begin wb_en = 1'b1; wb_data = dmem_rdata_i; end
            6'h2b: st_en = 1'b1;
            6'h04: begin taken = (exe_a == exe_b); target = pc4 + {simm[29:0], 2'b00}; end
            6'h05: begin taken = (exe_a != exe_b); target = pc4 + {simm[29:0], 2'b00}; end
            6'h02: begin taken = 1'b1; target = {pc4[31:28], exe_instr[25:0], 2'b00}; end
            6'h03: begin
                taken   = 1'b1;
                target  = {pc4[31:28], exe_instr[25:0], 2'b00};
                wb_en   = 1'b1;
                wb_addr = 5'd31;
                wb_data = pc4;
            end
            default: ;
        endcase
    end

    assign dmem_addr_o  = sum_imm[31:2];
    assign dmem_we_o    = st_en && en_i;
    assign dmem_wdata_o = exe_b;
endmodule

module soc #(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 1024
) (
    input logic clk,
    input logic reset,
    input logic system_ena,
    input logic pause
);
    logic        run_en, dmem_we;
    logic [29:0] imem_addr, dmem_addr;
    logic [31:0] imem_data, dmem_wdata, dmem_rdata;

    assign run_en = system_ena && !pause;

    soc_cpu core0 (
        .clk          (clk),
        .srst_i       (reset),
        .en_i         (run_en),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .dmem_addr_o  (dmem_addr),
        .dmem_we_o    (dmem_we),
        .dmem_wdata_o (dmem_wdata),
        .dmem_rdata_i (dmem_rdata)
    );

    soc_imem #(.WORDS(IMEM_WORDS)) imem_inst (
        .clk     (clk),
        .we_i    (1'b0),
        .waddr_i (30'd0),
        .wdata_i (32'd0),
        .raddr_i (imem_addr),
        .rdata_o (imem_data)
    );

    soc_dmem #(.WORDS(DMEM_WORDS)) dmem_inst (
        .clk     (clk),
        .we_i    (dmem_we),
        .addr_i  (dmem_addr),
        .wdata_i (dmem_wdata),
        .rdata_o (dmem_rdata)
    );
endmodule

// File: tb/tb_soc.sv
// Directed bench for soc: arithmetic/forwarding, load/store, branches and jumps,
// freeze via pause/system_ena, and reset both at start and mid-program.

module tb_soc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic system_ena = 1'b1;
    logic pause = 1'b0;
    int   checks = 0;
    int   failures = 0;

    soc dut (
        .clk        (clk),
        .reset      (reset),
        .system_ena (system_ena),
        .pause      (pause)
    );

    always #5 clk = ~clk;

    // Program 1: ALU ops, forwarding, lui/ori, sw/lw round trip, then j-to-self.
    logic [31:0] p1 [0:17] = '{
        32'h24010005, 32'h24220003, 32'h24000007, 32'h3C05ABCD,
        32'h34A51234, 32'h3C061234, 32'h34C65678, 32'hAC060008,
        32'h8C030008, 32'h00632021, 32'hAC04000C, 32'h00223823,
        32'h00E1402A, 32'h00E1482B, 32'h00075043, 32'h00075F02,
        32'h00006027, 32'h08000011
    };
    // Program 2: beq, bne, jal, jr with skipped instructions, then beq-to-self.
    logic [31:0] p2 [0:10] = '{
        32'h10000002, 32'h24010001, 32'h24020002, 32'h24030003,
        32'h14600001, 32'h24040004, 32'h0C00000A, 32'h24050005,
        32'h1000FFFF, 32'h00000000, 32'h03E00008
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
        $display("[%0t] check %s observed=%08h expected=%08h", $time, tag, obs, exp);
    endtask

    task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
        chk($sformatf("%s_r%0d", tag, r), dut.core0.gpr_inst.array_reg[r], exp);
    endtask

    task automatic chk_exe(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, "_pc"}, dut.core0.exe_pc_out, pc);
        chk({tag, "_instr"}, dut.core0.id_exe_reg_inst.exe_instr_out, instr);
    endtask

    task automatic chk_p1_final(input string tag);
        chk_reg(tag, 0, 32'h00000000);
        chk_reg(tag, 1, 32'h00000005);
        chk_reg(tag, 2, 32'h00000008);
        chk_reg(tag, 3, 32'h12345678);
        chk_reg(tag, 4, 32'h2468ACF0);
        chk_reg(tag, 5, 32'hABCD1234);
        chk_reg(tag, 6, 32'h12345678);
        chk_reg(tag, 7, 32'hFFFFFFFD);
        chk_reg(tag, 8, 32'h00000001);
        chk_reg(tag, 9, 32'h00000000);
        chk_reg(tag, 10, 32'hFFFFFFFE);
        chk_reg(tag, 11, 32'h0000000F);
        chk_reg(tag, 12, 32'hFFFFFFFF);
        chk({tag, "_dmem2"}, dut.dmem_inst.data_array[2], 32'h12345678);
        chk({tag, "_dmem3"}, dut.dmem_inst.data_array[3], 32'h2468ACF0);
    endtask

    initial begin
        // Load program 1 while reset is held.
        for (int i = 0; i < 1024; i++) dut.imem_inst.inst_array[i] <= 32'h0;
        for (int i = 0; i < 18; i++) dut.imem_inst.inst_array[i] <= p1[i];
        tick();
        tick();
        chk_exe("reset", 32'h0, 32'h0);
        for (int r = 0; r < 32; r++) chk_reg("reset", r, 32'h0);

        // First instruction reaches EXE on the second edge after release.
        reset = 1'b0;
        tick();
        chk_exe("edge1_bubble", 32'h0, 32'h0);
        tick();
        chk_exe("edge2", 32'h0, 32'h24010005);
        tick();
        chk_reg("fwd", 1, 32'h5);
        chk_exe("edge3", 32'h4, 32'h24220003);
        tick();
        chk_reg("fwd", 2, 32'h8);
        chk_exe("edge4", 32'h8, 32'h24000007);
        tick();
        chk_reg("r0_write", 0, 32'h0);
        chk_exe("edge5", 32'hC, 32'h3C05ABCD);
        repeat (20) tick();
        chk_p1_final("p1");

        // Mid-program reset wins over pause and system_ena; dmem survives.
        pause = 1'b1;
        system_ena = 1'b0;
        reset = 1'b1;
        tick();
        chk_exe("midrst", 32'h0, 32'h0);
        for (int r = 0; r < 32; r++) chk_reg("midrst", r, 32'h0);
        chk("midrst_dmem2", dut.dmem_inst.data_array[2], 32'h12345678);
        chk("midrst_dmem3", dut.dmem_inst.data_array[3], 32'h2468ACF0);
        reset = 1'b0;
        pause = 1'b0;
        system_ena = 1'b1;
        tick();
        tick();
        chk_exe("restart_e2", 32'h0, 32'h24010005);
        tick();
        chk_reg("restart", 1, 32'h5);
        chk_exe("restart_e3", 32'h4, 32'h24220003);
        repeat (4) tick();
        chk_exe("prepause", 32'h14, 32'h3C061234);
        chk_reg("prepause", 5, 32'hABCD1234);

        // Freeze for 30 cycles with pause, then a few more with system_ena low.
        pause = 1'b1;
        repeat (30) tick();
        chk_exe("paused", 32'h14, 32'h3C061234);
        chk_reg("paused", 1, 32'h5);
        chk_reg("paused", 2, 32'h8);
        chk_reg("paused", 5, 32'hABCD1234);
        chk_reg("paused", 6, 32'h0);
        pause = 1'b0;
        system_ena = 1'b0;
        repeat (3) tick();
        chk_exe("disabled", 32'h14, 32'h3C061234);
        chk_reg("disabled", 6, 32'h0);
        system_ena = 1'b1;
        tick();
        chk_exe("resumed", 32'h18, 32'h34C65678);
        chk_reg("resumed", 6, 32'h12340000);
        repeat (20) tick();
        chk_p1_final("p1_paused");

        // Program 2: control flow.
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) dut.imem_inst.inst_array[i] <= 32'h0;
        for (int i = 0; i < 11; i++) dut.imem_inst.inst_array[i] <= p2[i];
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk_exe("beq", 32'h0, 32'h10000002);
        tick();
        chk_exe("flush1", 32'h0, 32'h0);
        tick();
        chk_exe("flush2", 32'h0, 32'h0);
        tick();
        chk_exe("target", 32'hC, 32'h24030003);
        repeat (20) tick();
        chk_reg("p2", 1, 32'h0);
        chk_reg("p2", 2, 32'h0);
        chk_reg("p2", 3, 32'h3);
        chk_reg("p2", 4, 32'h0);
        chk_reg("p2", 5, 32'h5);
        chk_reg("p2", 31, 32'h1C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
